// File: rtl/mpf_prim_fifo_lutram_pkg.sv
// Shared helpers for the LUTRAM FIFO primitives: pointer-width derivation.
package mpf_prim_fifo_lutram_pkg;

    // Address width for a power-of-two depth; never narrower than one bit.
    function automatic int unsigned mpf_ptr_bits(input int unsigned n_entries);
        return (n_entries < 2) ? 1 : $clog2(n_entries);
    endfunction

endpackage

// File: rtl/mpf_prim_lutram.sv
// Distributed-RAM array: synchronous write port, asynchronous read port.
module mpf_prim_lutram
    import mpf_prim_fifo_lutram_pkg::*;
#(
    parameter int unsigned N_DATA_BITS = 32,
    parameter int unsigned N_ENTRIES   = 2,
    localparam int unsigned ADDR_W     = mpf_ptr_bits(N_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [N_DATA_BITS-1:0] wr_data,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [N_DATA_BITS-1:0] rd_data
);

    logic [N_DATA_BITS-1:0] mem [N_ENTRIES];

    // Write the addressed slot on the rising edge.
    // NOTE: the storage array has no reset; clearing it would stop it mapping
    // onto distributed RAM, and the pointers already mark every slot invalid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mpf_prim_fifo_lutram.sv
// Show-ahead FIFO on LUTRAM storage with an optional output register stage.
module mpf_prim_fifo_lutram
    import mpf_prim_fifo_lutram_pkg::*;
#(
    parameter int unsigned N_DATA_BITS     = 32,
    parameter int unsigned N_ENTRIES       = 2,
    parameter int unsigned THRESHOLD       = 1,
    parameter int unsigned REGISTER_OUTPUT = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_DATA_BITS-1:0] enq_data,
    input  logic                   enq_en,
    output logic                   notFull,
    output logic                   almostFull,
    output logic [N_DATA_BITS-1:0] first,
    input  logic                   deq_en,
    output logic                   notEmpty
);

    localparam int unsigned PTR_W = mpf_ptr_bits(N_ENTRIES);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q,  count_d;
    logic [CNT_W-1:0]       free_slots;
    logic [N_DATA_BITS-1:0] rd_data;
    logic                   enq_ok;
    logic                   deq_ok;
    logic                   core_pop;
    logic                   core_not_empty;

    mpf_prim_lutram #(
        .N_DATA_BITS (N_DATA_BITS),
        .N_ENTRIES   (N_ENTRIES)
    ) u_lutram (
        .clk     (clk),
        .wr_en   (enq_ok),
        .wr_addr (wr_ptr_q),
        .wr_data (enq_data),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    // Flags decode registered occupancy only, so strobes never reach outputs.
    assign core_not_empty = (count_q != '0);
    assign notFull        = (count_q != CNT_W'(N_ENTRIES));
    assign free_slots     = CNT_W'(N_ENTRIES) - count_q;
    assign almostFull     = (free_slots <= CNT_W'(THRESHOLD));

    // An enqueue into a full core is dropped outright.
    assign enq_ok = enq_en && notFull;

    // Next pointer and occupancy from the accepted push and the core pop.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (core_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({enq_ok, core_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the FIFO at once.
    // NOTE: clocked state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    if (REGISTER_OUTPUT != 0) begin : g_reg_out
        logic                   out_valid_q, out_valid_d;
        logic [N_DATA_BITS-1:0] out_data_q;

        // Refill the output stage whenever it is empty or being consumed.
        assign deq_ok      = deq_en && out_valid_q;
        assign core_pop    = core_not_empty && (!out_valid_q || deq_ok);
        assign out_valid_d = core_not_empty || (out_valid_q && !deq_ok);

        // Output stage register: holds the head entry off the LUTRAM read path.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
            end else begin
                out_valid_q <= out_valid_d;
                if (core_pop) begin
                    out_data_q <= rd_data;
                end
            end
        end

        assign first    = out_data_q;
        assign notEmpty = out_valid_q;
    end else begin : g_comb_out
        assign deq_ok   = deq_en && core_not_empty;
        assign core_pop = deq_ok;
        // Gate the unreset array so an empty FIFO presents zero.
        assign first    = core_not_empty ? rd_data : '0;
        assign notEmpty = core_not_empty;
    end

`ifndef SYNTHESIS
    // Flag protocol violations; the offending strobe is ignored by the logic.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(enq_en && !notFull))
                else $warning("mpf_prim_fifo_lutram: enq_en while full ignored");
            assert (!(deq_en && !notEmpty))
                else $warning("mpf_prim_fifo_lutram: deq_en while empty ignored");
        end
    end
`endif

endmodule

// File: tb/tb_mpf_prim_fifo_lutram.sv
// Directed scoreboard bench: one unregistered and one registered-output FIFO.
module tb_mpf_prim_fifo_lutram;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] enq_data0, enq_data1, first0, first1;
    logic        enq0, deq0, enq1, deq1;
    logic        nf0, af0, ne0, nf1, af1, ne1;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    always #5 clk = ~clk;

    mpf_prim_fifo_lutram #(
        .N_DATA_BITS(32), .N_ENTRIES(8), .THRESHOLD(2), .REGISTER_OUTPUT(0)
    ) u_dut0 (
        .clk(clk), .reset(reset), .enq_data(enq_data0), .enq_en(enq0),
        .notFull(nf0), .almostFull(af0), .first(first0), .deq_en(deq0),
        .notEmpty(ne0)
    );

    mpf_prim_fifo_lutram #(
        .N_DATA_BITS(32), .N_ENTRIES(8), .THRESHOLD(2), .REGISTER_OUTPUT(1)
    ) u_dut1 (
        .clk(clk), .reset(reset), .enq_data(enq_data1), .enq_en(enq1),
        .notFull(nf1), .almostFull(af1), .first(first1), .deq_en(deq1),
        .notEmpty(ne1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
            else begin
                n_err++;
                $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            end
    endtask

    // Advance one clock; outputs are then settled 1 ns past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_v;
        int          w;

        reset = 1'b1;
        enq0 = 1'b0; deq0 = 1'b0; enq1 = 1'b0; deq1 = 1'b0;
        enq_data0 = '0; enq_data1 = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state of both configurations
        check("rst_nf0", nf0, 1); check("rst_ne0", ne0, 0);
        check("rst_af0", af0, 0); check("rst_first0", first0, 0);
        check("rst_nf1", nf1, 1); check("rst_ne1", ne1, 0);
        check("rst_af1", af1, 0); check("rst_first1", first1, 0);
        reset = 1'b0;
        tick();

        // Enqueue 0xA5 into empty FIFOs: 1-cycle vs 2-cycle latency
        enq0 = 1'b1; enq1 = 1'b1; enq_data0 = 32'hA5; enq_data1 = 32'hA5;
        tick();
        enq0 = 1'b0; enq1 = 1'b1 & 1'b0;
        check("a5_ne0_1cyc", ne0, 1);
        check("a5_first0", first0, 32'hA5);
        check("a5_ne1_1cyc", ne1, 0);
        tick();
        check("a5_ne1_2cyc", ne1, 1);
        check("a5_first1", first1, 32'hA5);
        deq0 = 1'b1; deq1 = 1'b1;
        tick();
        deq0 = 1'b0; deq1 = 1'b0;
        check("a5_ne0_drained", ne0, 0);
        check("a5_ne1_drained", ne1, 0);

        // Fill dut0 with 0..7: almostFull after the 6th write, full after 8th
        for (int i = 0; i < 8; i++) begin
            enq0 = 1'b1; enq_data0 = 32'(i); q0.push_back(32'(i));
            tick();
            check($sformatf("fill_af0_%0d", i), af0, (i >= 5) ? 1 : 0);
            check($sformatf("fill_nf0_%0d", i), nf0, (i < 7) ? 1 : 0);
        end
        // A 9th enqueue on a full FIFO must be dropped
        enq_data0 = 32'h99;
        tick();
        enq0 = 1'b0;
        check("drop_nf0", nf0, 0);
        check("drop_head0", first0, 0);
        for (int k = 0; k < 8; k++) begin
            exp_v = q0.pop_front();
            check($sformatf("drain0_ne_%0d", k), ne0, 1);
            check($sformatf("drain0_data_%0d", k), first0, exp_v);
            deq0 = 1'b1;
            tick();
            if (k == 0) check("drain0_nf_rise", nf0, 1);
        end
        deq0 = 1'b0;
        check("drain0_empty", ne0, 0);

        // Registered-output FIFO holds 9 before notFull drops
        for (int i = 0; i < 9; i++) begin
            enq1 = 1'b1; enq_data1 = 32'h100 + 32'(i); q1.push_back(32'h100 + 32'(i));
            tick();
            check($sformatf("fill_nf1_%0d", i), nf1, (i < 8) ? 1 : 0);
        end
        enq1 = 1'b0;
        for (int k = 0; k < 9; k++) begin
            exp_v = q1.pop_front();
            check($sformatf("drain1_ne_%0d", k), ne1, 1);
            check($sformatf("drain1_data_%0d", k), first1, exp_v);
            deq1 = 1'b1;
            tick();
        end
        deq1 = 1'b0;
        check("drain1_empty", ne1, 0);

        // Streaming: prefill 3, then 100 cycles of simultaneous enq/deq
        for (int i = 0; i < 3; i++) begin
            enq0 = 1'b1; enq1 = 1'b1;
            enq_data0 = 32'h200 + 32'(i); enq_data1 = 32'h200 + 32'(i);
            q0.push_back(32'h200 + 32'(i)); q1.push_back(32'h200 + 32'(i));
            tick();
        end
        enq0 = 1'b0; enq1 = 1'b0;
        tick();
        for (int c = 0; c < 100; c++) begin
            exp_v = q0.pop_front();
            check($sformatf("stream0_%0d", c), first0, exp_v);
            exp_v = q1.pop_front();
            check($sformatf("stream1_%0d", c), first1, exp_v);
            enq0 = 1'b1; deq0 = 1'b1; enq1 = 1'b1; deq1 = 1'b1;
            enq_data0 = 32'h1000 + 32'(c); enq_data1 = 32'h1000 + 32'(c);
            q0.push_back(32'h1000 + 32'(c)); q1.push_back(32'h1000 + 32'(c));
            tick();
        end
        enq0 = 1'b0; deq0 = 1'b0; enq1 = 1'b0; deq1 = 1'b0;
        check("stream_af0", af0, 0);
        check("stream_nf1", nf1, 1);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("sdrain0_ne_%0d", k), ne0, 1);
            check($sformatf("sdrain1_ne_%0d", k), ne1, 1);
            exp_v = q0.pop_front();
            check($sformatf("sdrain0_data_%0d", k), first0, exp_v);
            exp_v = q1.pop_front();
            check($sformatf("sdrain1_data_%0d", k), first1, exp_v);
            deq0 = 1'b1; deq1 = 1'b1;
            tick();
        end
        deq0 = 1'b0; deq1 = 1'b0;
        check("sdrain0_empty", ne0, 0);
        check("sdrain1_empty", ne1, 0);

        // Asynchronous reset with 5 entries queued
        for (int i = 0; i < 5; i++) begin
            enq0 = 1'b1; enq1 = 1'b1;
            enq_data0 = 32'h300 + 32'(i); enq_data1 = 32'h300 + 32'(i);
            tick();
        end
        enq0 = 1'b0; enq1 = 1'b0;
        tick();
        check("pre_rst_ne0", ne0, 1);
        check("pre_rst_ne1", ne1, 1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_ne0", ne0, 0); check("arst_nf0", nf0, 1);
        check("arst_af0", af0, 0); check("arst_first0", first0, 0);
        check("arst_ne1", ne1, 0); check("arst_nf1", nf1, 1);
        check("arst_af1", af1, 0); check("arst_first1", first1, 0);
        q0.delete(); q1.delete();
        tick();
        reset = 1'b0;
        tick();
        enq0 = 1'b1; enq1 = 1'b1; enq_data0 = 32'h77; enq_data1 = 32'h77;
        q0.push_back(32'h77); q1.push_back(32'h77);
        tick();
        enq0 = 1'b0; enq1 = 1'b0;
        w = 0;
        while (!ne1 && w < 4) begin
            tick();
            w++;
        end
        check("post_rst_ne0", ne0, 1);
        check("post_rst_ne1", ne1, 1);
        exp_v = q0.pop_front();
        check("post_rst_first0", first0, exp_v);
        exp_v = q1.pop_front();
        check("post_rst_first1", first1, exp_v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
